// File: rtl/uart_transmitter_if.sv
// Handshake and line signals between system-side command logic and the UART transmitter.
// The master drives the start request and byte; the slave (transmitter) drives the line.
interface uart_transmitter_if #(
   parameter int DATA_BITS = 8
);
   logic                 transmit;
   logic [DATA_BITS-1:0] data_in;
   logic                 serial_out;
   logic                 busy;
   logic                 done;

   modport master (
      output transmit, data_in,
      input  serial_out, busy, done
   );

   modport slave (
      input  transmit, data_in,
      output serial_out, busy, done
   );
endinterface

// File: rtl/uart_transmitter.sv
// Asynchronous serial transmitter: start bit, data LSB first, optional parity, 1 or 2 stop bits.
// All outputs are registered so the TX pin never glitches.
module uart_transmitter #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              reset,
   uart_transmitter_if.slave tx
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 parity_q, parity_d;
   logic                 serial_q, serial_d;
   logic                 done_q, done_d;
   logic                 bit_end;

   assign bit_end = (cnt_q == CNT_LAST);

   always_comb begin
      // NOTE: every next-value gets a default first so no path through the case infers a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      done_d   = 1'b0;

      if (state_q != S_IDLE) cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);

      case (state_q)
         S_IDLE: begin
            if (tx.transmit) begin
               state_d  = S_START;
               cnt_d    = '0;
               idx_d    = '0;
               shift_d  = tx.data_in;
               parity_d = (^tx.data_in) ^ (PARITY_ODD != 0);
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               idx_d   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (idx_q == DATA_LAST) begin
                  idx_d   = '0;
                  state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               idx_d   = '0;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (idx_q == STOP_LAST) begin
                  state_d = S_IDLE;
                  idx_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Line level is derived from the upcoming state so it lands in the register with the state.
      case (state_d)
         S_START:  serial_d = 1'b0;
         S_DATA:   serial_d = shift_d[0];
         S_PARITY: serial_d = parity_q;
         default:  serial_d = 1'b1;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         serial_q <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         serial_q <= serial_d;
         done_q   <= done_d;
      end
   end

   assign tx.serial_out = serial_q;
   assign tx.busy       = (state_q != S_IDLE);
   assign tx.done       = done_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: four frame formats at 4 clocks per bit, checked cycle by cycle
// against a queue of expected line/busy/done values built from the byte being sent.
module tb_uart_transmitter;
   localparam int CPB = 4;

   typedef struct packed {
      logic so;
      logic busy;
      logic done;
   } obs_t;

   localparam obs_t IDLE_OBS = 3'b100;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] tx_go = '0;
   logic [7:0] data  = '0;
   int         sel   = 0;
   int         n_cmp = 0;
   int         n_fail = 0;
   string      tag   = "reset";
   obs_t       q[$];

   always #5 clk = ~clk;

   uart_transmitter_if #(.DATA_BITS(8)) if_n1 ();
   uart_transmitter_if #(.DATA_BITS(8)) if_e1 ();
   uart_transmitter_if #(.DATA_BITS(8)) if_o1 ();
   uart_transmitter_if #(.DATA_BITS(8)) if_n2 ();

   assign if_n1.transmit = tx_go[0];
   assign if_e1.transmit = tx_go[1];
   assign if_o1.transmit = tx_go[2];
   assign if_n2.transmit = tx_go[3];
   assign if_n1.data_in  = data;
   assign if_e1.data_in  = data;
   assign if_o1.data_in  = data;
   assign if_n2.data_in  = data;

   uart_transmitter #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
      u_n1 (.clk(clk), .reset(reset), .tx(if_n1));
   uart_transmitter #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
      u_e1 (.clk(clk), .reset(reset), .tx(if_e1));
   uart_transmitter #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
      u_o1 (.clk(clk), .reset(reset), .tx(if_o1));
   uart_transmitter #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
      u_n2 (.clk(clk), .reset(reset), .tx(if_n2));

   function automatic obs_t get_obs(int s);
      case (s)
         0:       return {if_n1.serial_out, if_n1.busy, if_n1.done};
         1:       return {if_e1.serial_out, if_e1.busy, if_e1.done};
         2:       return {if_o1.serial_out, if_o1.busy, if_o1.done};
         default: return {if_n2.serial_out, if_n2.busy, if_n2.done};
      endcase
   endfunction

   function automatic int cfg_pe(int s);
      return (s == 1 || s == 2) ? 1 : 0;
   endfunction

   function automatic int cfg_sb(int s);
      return (s == 3) ? 2 : 1;
   endfunction

   function automatic int frame_len(int s);
      return CPB * (1 + 8 + cfg_pe(s) + cfg_sb(s));
   endfunction

   task automatic check(input obs_t got, input obs_t exp);
      n_cmp++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed so/busy/done=%b required %b", tag, got, exp);
      end
   endtask

   // Expected values for the selected DUT: one entry per busy cycle, then the done cycle.
   task automatic push_frame(input logic [7:0] d);
      logic bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (cfg_pe(sel) != 0) bits.push_back((^d) ^ (sel == 2));
      for (int i = 0; i < cfg_sb(sel); i++) bits.push_back(1'b1);
      foreach (bits[i]) repeat (CPB) q.push_back({bits[i], 1'b1, 1'b0});
      q.push_back(3'b101);
   endtask

   task automatic run_cycles(input int n);
      obs_t exp;
      repeat (n) begin
         @(posedge clk);
         #1;
         exp = (q.size() > 0) ? q.pop_front() : IDLE_OBS;
         check(get_obs(sel), exp);
      end
   endtask

   task automatic send(input logic [7:0] d);
      data       = d;
      tx_go[sel] = 1'b1;
      push_frame(d);
      run_cycles(1);
      tx_go = '0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 4; s++) check(get_obs(s), IDLE_OBS);
      reset = 1'b0;
      run_cycles(2);

      sel = 0; tag = "8N1 0x55";
      send(8'h55);
      run_cycles(frame_len(sel) + 3);

      tag = "reset+transmit";
      reset = 1'b1; data = 8'hC3; tx_go[0] = 1'b1;
      run_cycles(1);
      reset = 1'b0; tx_go = '0;
      run_cycles(3);

      tag = "ignore mid-frame 0xFF";
      send(8'h0F);
      run_cycles(10);
      data = 8'hFF; tx_go[0] = 1'b1;
      run_cycles(1);
      tx_go = '0;
      run_cycles(frame_len(sel) - 11 + 4);

      tag = "back-to-back 0x12";
      send(8'h12);
      run_cycles(frame_len(sel));
      tag = "back-to-back 0x34";
      send(8'h34);
      run_cycles(frame_len(sel) + 3);

      tag = "reset in data bit 2";
      send(8'h81);
      run_cycles(13);
      reset = 1'b1;
      q.delete();
      run_cycles(1);
      reset = 1'b0;
      run_cycles(3);
      tag = "frame after reset 0x3C";
      send(8'h3C);
      run_cycles(frame_len(sel) + 2);

      sel = 1; tag = "8E1 0xA5";
      send(8'hA5);
      run_cycles(frame_len(sel) + 2);

      sel = 2; tag = "8O1 0xA5";
      send(8'hA5);
      run_cycles(frame_len(sel) + 2);

      sel = 3; tag = "8N2 0x00";
      send(8'h00);
      run_cycles(frame_len(sel) + 2);

      sel = 1; tag = "8E1 0x07";
      send(8'h07);
      run_cycles(frame_len(sel) + 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit side of the UART. It accepts a parallel byte through a single-cycle start handshake and shifts it out on `serial_out` as a standard asynchronous frame: start bit, data LSB first, optional parity, then stop bit(s). It is the counterpart of the receive path and uses the same clocks-per-bit baud convention. It sits between the system-side command logic and the TX pin.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per serial bit (115200 baud at 50 MHz); legal range ≥ 2.
- `DATA_BITS`, 8, data bits per frame; legal range 5–8.
- `PARITY_EN`, 0, 1 = append a parity bit after the data bits.
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd parity; ignored when `PARITY_EN` = 0.
- `STOP_BITS`, 1, number of stop bits; legal values 1 or 2.

- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `transmit`  input  1  start request; sampled every cycle.
- `data_in`  input  DATA_BITS  byte to send; captured only when a start is accepted.
- `serial_out`  output  1  TX line; idles high.
- `busy`  output  1  high while a frame is in progress.
- `done`  output  1  one-cycle pulse when the final stop bit completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Baud counter:
  - Width is ceil(log2(CLKS_PER_BIT)).
  - Counts 0..CLKS_PER_BIT-1 and is cleared on every bit transition.
  - A bit ends on the cycle where the count equals CLKS_PER_BIT-1.
- Bit index counter: counts 0..DATA_BITS-1 in DATA, and 0..STOP_BITS-1 in STOP.
- Transitions:
  - IDLE→START when `transmit`=1. `data_in` is latched into a shift register and parity is computed from the latched value.
  - START→DATA at the end of the start bit.
  - DATA→DATA at the end of each bit, shifting right.
  - DATA→PARITY (if PARITY_EN) or DATA→STOP after bit DATA_BITS-1.
  - PARITY→STOP at the end of the parity bit.
  - STOP→IDLE at the end of the last stop bit.
- `serial_out` is registered:
  - IDLE = 1.
  - START = 0.
  - DATA = current LSB of the shift register.
  - PARITY = XOR of the latched data bits, inverted when PARITY_ODD=1.
  - STOP = 1.
- `busy` = 1 in every state except IDLE. `transmit` while `busy`=1 is ignored; there is no queuing and `data_in` is not sampled.
- `done` is registered. It is 1 for exactly the first IDLE cycle after STOP and 0 otherwise.
- Reset values: state IDLE, `serial_out`=1, `busy`=0, `done`=0, all counters 0.
- Reset mid-frame: the frame is aborted. On the cycle after reset is sampled high, `serial_out`=1 and `busy`=0; `done` is not asserted.

## Timing
- Start latency: `transmit` sampled high at edge N (while IDLE) gives `serial_out`=0 and `busy`=1 from edge N+1.
- Every bit is exactly CLKS_PER_BIT cycles long, with no jitter.
- Frame length F = CLKS_PER_BIT × (1 + DATA_BITS + PARITY_EN + STOP_BITS). `busy` is high for exactly F cycles.
- `done` rises on edge N+1+F, in the same cycle that `busy` falls.
- Back-to-back frames: `transmit` high in the `done` cycle is accepted, and the next start bit begins one cycle later. Minimum idle gap between frames is 1 cycle beyond the stop bits.
- Simultaneous `reset` and `transmit`: reset wins and the request is dropped.

## Test plan
- **8N1, CLKS_PER_BIT=4, data 0x55:** one-cycle `transmit` → `serial_out` shows 0, then 1,0,1,0,1,0,1,0, then 1, each level held 4 cycles. `busy` is high for 40 cycles, then `done` pulses once.
- **8E1, CLKS_PER_BIT=4, data 0xA5 (four ones):** parity bit = 0. With PARITY_ODD=1 the parity bit = 1. `busy` is high for 44 cycles.
- **8N2, data 0x00:** the low period is 9×CLKS_PER_BIT and the stop high is 2×CLKS_PER_BIT before `done`. `busy` lasts 11×CLKS_PER_BIT cycles.
- **`transmit` with 0xFF pulsed mid-frame while sending 0x0F:** the waveform is exactly the 0x0F frame, and only one `done` pulse occurs.
- **Back-to-back 0x12 then 0x34, second `transmit` in the `done` cycle:** the second start bit begins one cycle after `done`, and both frames decode correctly.
- **`reset` asserted in the 3rd data bit:** the next cycle shows `serial_out`=1, `busy`=0, `done`=0. A new `transmit` after reset produces a full, correct frame.
